// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the data-memory load/store unit.
//   - request size encodings (SZ_*)
//   - FSM state type lsu_state_t
//   - lane-selection constants and small helpers used by dmem_lsu and
//     dmem_lsu_align
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_t;

  // A byte offset becomes a bit offset by appending this many zero bits.
  localparam int          LANE_SHIFT = 3;
  localparam logic [31:0] BYTE_MASK  = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK  = 32'h0000_FFFF;

  // The reserved size code is handled exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

  // Expects an already normalised size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Forces the byte offset down to the natural alignment of the size.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: combinational lane logic for the load/store unit.
// One instance serves both paths of the read-data cycle:
//   load extract : o_load   = lane of i_word at i_off, sign/zero extended
//   store merge  : o_merged = i_word with i_new's low bytes placed at i_off
// Ports:
//   i_word     old / read memory word
//   i_off      byte offset within the word (already naturally aligned)
//   i_size     normalised access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_unsigned 1 = zero-extend loads
//   i_new      store data, low bytes used
//   o_load     extended load value
//   o_merged   word to write back for a sub-word store
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_new,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_lane_mask;

  assign w_shamt   = {i_off, {LANE_SHIFT{1'b0}}};
  assign w_shifted = i_word >> w_shamt;

  always_comb begin
    o_load      = i_word;
    w_lane_mask = 32'hFFFF_FFFF;
    case (i_size)
      SZ_BYTE: begin
        o_load      = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
        w_lane_mask = BYTE_MASK << w_shamt;
      end
      SZ_HALF: begin
        o_load      = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        w_lane_mask = HALF_MASK << w_shamt;
      end
      default: begin
        o_load      = i_word;
        w_lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    o_merged = (i_word & ~w_lane_mask) | ((i_new << w_shamt) & w_lane_mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the pipeline MEM stage and a
// word-addressed data memory with one-cycle registered read data.
// Byte/half stores are done as read-modify-write.
// Optional build macro: DMEM_LSU_MISALIGN_TRAP_EN
//   defined   : misaligned requests skip memory and respond with err=1
//   undefined : the address is forced to natural alignment, err is 0
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// resp_valid_o and resp_ready_i are both 1. A valid side holds its payload
// stable until the transfer happens.
// Ports:
//   clk_i, reset_i (sync, active low)
//   req_*  : request from pipeline (valid/ready)
//   resp_* : registered response to pipeline (valid/ready)
//   mem_*  : data memory port (word index, write data, we, re, read data)
//   dbg_state_o : current FSM state
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int WIDX_W     = $clog2(DMEM_DEPTH)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  output logic [2:0]  dbg_state_o
);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t          r_state;
  logic                r_store;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [WIDX_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [1:0]          w_size;
  logic                w_mis;
  logic [WIDX_W+1:0]   w_addr_eff;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic                w_unused_addr_hi;

  // Bytes above the memory size simply wrap.
  assign w_unused_addr_hi = |req_addr_i[31:WIDX_W+2];

  assign w_size     = norm_size(req_size_i);
  assign w_mis      = is_misaligned(w_size, req_addr_i[1:0]);
  assign w_addr_eff = {req_addr_i[WIDX_W+1:2],
                       TRAP_EN ? req_addr_i[1:0] : align_off(w_size, req_addr_i[1:0])};

  dmem_lsu_align u_align (
    .i_word     (mem_rdata_i),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_new      (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state     <= ST_IDLE;
      r_store     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_store    <= req_store_i;
            r_size     <= w_size;
            r_unsigned <= req_unsigned_i;
            r_addr     <= w_addr_eff;
            r_wdata    <= req_wdata_i;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            if (TRAP_EN && w_mis) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else if (!req_store_i) begin
              r_state <= ST_RD;
            end else if (w_size == SZ_WORD) begin
              r_mem_wdata <= req_wdata_i;
              r_state     <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          // mem_rdata_i carries the word requested in ST_RD.
          if (r_store) begin
            r_mem_wdata <= w_merged;
            r_state     <= ST_WR;
          end else begin
            r_rdata <= w_load;
            r_state <= ST_RESP;
          end
        end
        ST_WR: r_state <= ST_RESP;
        ST_RESP: begin
          if (resp_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign resp_valid_o = (r_state == ST_RESP);
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = TRAP_EN & r_err;
  assign mem_re_o     = (r_state == ST_RD);
  assign mem_we_o     = (r_state == ST_WR);
  assign mem_addr_o   = {{(32-WIDX_W){1'b0}}, r_addr[WIDX_W+1:2]};
  assign mem_wdata_o  = r_mem_wdata;
  assign dbg_state_o  = r_state;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that initiates accesses to the data memory from the pipeline MEM stage.
- The data memory is word-addressed, writes whole words only, and returns read data registered one cycle after its read enable.
- This block accepts byte, halfword and word load/store requests from the pipeline and drives the data memory port. It does load extraction with sign or zero extension, and performs sub-word stores as read-modify-write.
- Replies to the pipeline with a registered response under a valid/ready handshake.

Parameters:
- DMEM_DEPTH, 256, number of 32-bit words in data memory.
- WIDX_W, $clog2(DMEM_DEPTH) = 8, width of the word index driven on mem_addr_o.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE.
- req_store_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned_i  in  1  zero-extend loads.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data; only the low bytes selected by size are used.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  pipeline accepts response.
- resp_rdata_o  out  32  extended load data; 0 for stores.
- resp_err_o  out  1  misaligned access.
- mem_addr_o  out  32  word index = req_addr[WIDX_W+1:2], zero-extended.
- mem_wdata_o  out  32  word to write.
- mem_we_o  out  1  memory write enable.
- mem_re_o  out  1  memory read enable.
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_re_o.

Behaviour:
- **Reset (reset_i=0 at an edge):**
  - state goes to IDLE.
  - resp_valid_o, resp_err_o, resp_rdata_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o are all 0.
  - Any in-flight request is dropped; no write is issued for it.
- **States:** IDLE, RD, RD_WAIT, WR, RESP.
- **Memory-side outputs:** decoded from state plus the registered request.
  - mem_re_o = 1 only in RD.
  - mem_we_o = 1 only in WR.
  - mem_addr_o is held constant from RD through WR.
- **IDLE:** a request is accepted when req_valid_i & req_ready_o; all fields are latched. Next state:
  - misaligned (half with addr[0]=1, or word with addr[1:0]≠0) → RESP with err=1.
  - load → RD.
  - word store → WR, with wdata = req_wdata.
  - byte/half store → RD.
- **RD:** one cycle, then → RD_WAIT.
- **RD_WAIT:** mem_rdata_i is valid in this cycle.
  - Load: extract the byte/half selected by addr[1:0] (little-endian), extend it (sign unless req_unsigned), register it into resp_rdata → RESP.
  - Sub-word store: merge the store bytes into mem_rdata_i at the lanes selected by addr[1:0], register the result into mem_wdata → WR.
- **WR:** one cycle, then → RESP.
- **RESP:** resp_valid_o=1; response fields are held stable until resp_ready_i=1, then → IDLE.
  - No new request is accepted in the same cycle the response is accepted.
- **Latency (accept edge = T), in cycles until resp_valid_o rises:**
  - load: 3.
  - word store: 2.
  - sub-word store: 4.
  - misaligned: 1.
- **Address wrap:** address bits above WIDX_W+1 are ignored, so addresses wrap modulo 4*DMEM_DEPTH bytes.
- **Reserved size 11:** behaves as word.
- **Concurrency:** only one outstanding request at a time; req_ready_o=0 in every state except IDLE.

Optional Feature:
- Macro name: DMEM_LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are not sent to memory; they produce a response with resp_err_o=1 and resp_rdata_o=0.
- Undefined:
  - address low bits are masked to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.
  - resp_err_o is tied 0.

Decomposition:
- Package dmem_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum lsu_state_t.
  - helper constants for lane selection.
- One combinational sub-module, dmem_lsu_align:
  - load extract/extend: inputs word, offset, size, unsigned.
  - store merge: inputs old word, new data, offset, size.
  - Reused by RD_WAIT for both paths.

Test Plan:
- Word store 0x11223344 to 0x40, then word load from 0x40 → mem_we_o at T+1 with mem_addr_o=0x10; load resp_rdata_o=0x11223344 at T+3.
- With 0x40 holding 0x11223344, SB 0xAB to 0x41 → RD, RD_WAIT, WR with mem_wdata_o=0x1122AB44; response at T+4.
- LB from 0x41 → 0xFFFFFFAB; LBU → 0x000000AB; LH from 0x42 → 0x00001122.
- LH from 0x43 with macro defined → resp_err_o=1 at T+1, mem_re_o/mem_we_o never asserted. Without the macro → reads lane 0x42, err=0.
- Hold resp_ready_i=0 for 5 cycles after a load → resp_valid_o and resp_rdata_o stay stable, req_ready_o=0; accept on release, and req_ready_o=1 the next cycle.
- Assert reset_i=0 during RD_WAIT of a sub-word store → mem_we_o never pulses; memory word unchanged; all outputs 0; IDLE after release.
